// File: rtl/split_parallel_to_serial_pkg.sv
// Shared definitions for the parallel/serial stream paths: lane state encoding,
// serial beat layout and the helpers that define where each field sits in a word.
package split_parallel_to_serial_pkg;

  // Per-lane serializer state
  typedef enum logic {
    LANE_IDLE  = 1'b0,
    LANE_SHIFT = 1'b1
  } lane_state_e;

  // One beat on a 1-bit valid/ready serial stream
  typedef struct packed {
    logic valid;
    logic data;
  } serial_beat_t;

  // Bit offset of a field inside the merged word: field 0 starts at bit 0,
  // field 1 starts directly above field 0.
  function automatic int field_offset(input int field_idx, input int width_1);
    return (field_idx == 0) ? 0 : width_1;
  endfunction

  // Bit-counter width for a lane of the given width; a 1-bit lane still gets a 1-bit counter.
  function automatic int cnt_width(input int lane_width);
    return $clog2((lane_width < 2) ? 2 : lane_width);
  endfunction

endpackage

// File: rtl/split_parallel_to_serial_p2s.sv
// Single-lane serializer: loads an IN_WIDTH field on request and shifts it out
// LSB first on a 1-bit valid/ready stream, reporting idle once fully drained.
module parallel_to_serial
  import split_parallel_to_serial_pkg::*;
#(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                load,
  input  logic [IN_WIDTH-1:0] load_data,
  output logic                idle,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_data
);

  localparam int CW = cnt_width(IN_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(IN_WIDTH - 1);

  lane_state_e         state_q, state_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Next-state logic: load on request while idle, shift on each accepted beat
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      LANE_IDLE: begin
        if (load) begin
          state_d = LANE_SHIFT;
          shift_d = load_data;
          cnt_d   = '0;
        end
      end
      LANE_SHIFT: begin
        if (m_ready) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = LANE_IDLE;
          end
        end
      end
      default: state_d = LANE_IDLE;
    endcase
  end

  // State, shift register and bit counter, cleared asynchronously
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= LANE_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idle    = (state_q == LANE_IDLE);
  assign m_valid = (state_q == LANE_SHIFT);
  assign m_data  = shift_q[0];

endmodule

// File: rtl/split_parallel_to_serial.sv
// Accepts one parallel word, splits it into two fields and serializes each field
// on its own independent 1-bit stream; a new word is taken once both lanes are idle.
module split_parallel_to_serial
  import split_parallel_to_serial_pkg::*;
#(
  parameter int WIDTH_1  = 3,
  parameter int WIDTH_2  = 8,
  parameter int IN_WIDTH = WIDTH_1 + WIDTH_2
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_data,
  output logic                m_valid_1,
  input  logic                m_ready_1,
  output logic                m_data_1,
  output logic                m_valid_2,
  input  logic                m_ready_2,
  output logic                m_data_2
);

  localparam int F1_LO = field_offset(0, WIDTH_1);
  localparam int F2_LO = field_offset(1, WIDTH_1);

  logic idle_1, idle_2;
  logic accept;

  // s_ready depends only on registered lane state, never on m_ready or s_valid
  assign s_ready = idle_1 && idle_2;
  assign accept  = s_valid && s_ready;

  parallel_to_serial #(.IN_WIDTH(WIDTH_1)) u_lane_1 (
    .clk       (clk),
    .aresetn   (aresetn),
    .load      (accept),
    .load_data (s_data[F1_LO +: WIDTH_1]),
    .idle      (idle_1),
    .m_valid   (m_valid_1),
    .m_ready   (m_ready_1),
    .m_data    (m_data_1)
  );

  parallel_to_serial #(.IN_WIDTH(WIDTH_2)) u_lane_2 (
    .clk       (clk),
    .aresetn   (aresetn),
    .load      (accept),
    .load_data (s_data[F2_LO +: WIDTH_2]),
    .idle      (idle_2),
    .m_valid   (m_valid_2),
    .m_ready   (m_ready_2),
    .m_data    (m_data_2)
  );

endmodule

// File: doc/split_parallel_to_serial.md
Name: split_parallel_to_serial

Overview:
- Downstream consumer of the merged parallel word: takes one OUT_WIDTH word over a valid/ready handshake.
- Splits the word into two fields and serializes each field onto its own 1-bit valid/ready stream, LSB first.
- The two serial streams drain independently. A new word is accepted only when both streams have fully drained.
- This makes the block the inverse of the serial-to-parallel-and-merge path; the two are used back to back for loopback tests.

Parameters:
- WIDTH_1, 3, width of field 1, taken from s_data[WIDTH_1-1:0]; must be >= 1.
- WIDTH_2, 8, width of field 2, taken from s_data[OUT_WIDTH-1:WIDTH_1]; must be >= 1.
- IN_WIDTH, WIDTH_1 + WIDTH_2, width of the parallel input word.

Ports:
- clk  input  1  clock, rising-edge.
- aresetn  input  1  asynchronous active-low reset.
- s_valid  input  1  parallel word valid.
- s_ready  output  1  block can accept a word.
- s_data  input  IN_WIDTH  parallel word.
- m_valid_1  output  1  serial stream 1 bit valid.
- m_ready_1  input  1  serial stream 1 sink ready.
- m_data_1  output  1  serial stream 1 bit.
- m_valid_2  output  1  serial stream 2 bit valid.
- m_ready_2  input  1  serial stream 2 sink ready.
- m_data_2  output  1  serial stream 2 bit.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous, active-low (aresetn).
- Reset values: s_ready=1, m_valid_1=0, m_valid_2=0, m_data_1=0, m_data_2=0. Shift registers and counters are cleared.
- Handshake rule (all ports): a transfer occurs on a rising edge where valid && ready.
  - Once asserted, m_valid_x stays high and m_data_x stays stable until its transfer.
- Each lane is a two-state FSM: IDLE and SHIFT.
- IDLE -> SHIFT: on the input transfer edge.
  - Both lanes load their field together and enter SHIFT together.
  - Lane x loads shift register = field x and bit counter = 0.
- Latency: m_valid_x=1 in the cycle after the input transfer, with m_data_x = field bit 0.
- In SHIFT:
  - m_valid_x=1 and m_data_x = shift register bit 0.
  - On each m_valid_x && m_ready_x: shift right by one and increment the counter.
  - On the transfer of bit WIDTH_x-1: return to IDLE. m_valid_x=0 the following cycle.
- Lanes drain independently; a stalled sink (m_ready_x low) never blocks the other lane.
- s_ready = (lane1 in IDLE) && (lane2 in IDLE).
  - Driven from registered state only; there is no combinational path from m_ready_x or s_valid to s_ready.
  - Consequence: there is always at least one cycle gap between the last serial transfer and the next word accept.
  - Peak throughput is one word per max(WIDTH_1, WIDTH_2)+1 cycles.
- s_data is sampled only on the accept edge; s_data changes while s_ready=0 are ignored.
- m_ready_x asserted while m_valid_x=0 has no effect.
- Counter width is $clog2(max(WIDTH_x,2)). WIDTH_x=1 is legal: exactly one serial transfer.
- Reset mid-operation: the partially serialized word is discarded. All outputs return to reset values immediately (asynchronously), and the block is idle with s_ready=1 at the first edge after release.

Decomposition:
- Shared bus package: the valid/ready stream convention and the field-offset function for a field start position. Both the merge and split paths import the offset function so the field layout is defined in exactly one place.
- Sub-module parallel_to_serial (parameter IN_WIDTH), one instance per lane. Each instance owns the per-lane FSM, shift register and counter. It exposes an idle flag used by the top level to form s_ready.

Test Plan:
- Reset values: hold aresetn=0 -> s_ready=1, m_valid_1=0, m_valid_2=0; release -> s_ready stays 1.
- Basic split, m_ready_1=m_ready_2=1, s_data=11'b10110100_101:
  - stream 1 emits 1,0,1 on 3 consecutive cycles starting one cycle after accept;
  - stream 2 emits 0,0,1,0,1,1,0,1 (field 0xB4, LSB first);
  - s_ready=0 from the accept edge until the cycle after the last stream-2 transfer.
- Independent backpressure, same word: m_ready_2=0 throughout, m_ready_1=1 ->
  - stream 1 completes all 3 bits;
  - m_valid_2 stays 1 with m_data_2=0 held;
  - s_ready stays 0;
  - raising m_ready_2 drains the remaining 8 bits, then s_ready=1.
- Back-to-back words, s_valid held high with 0x7FF then 0x000 -> second word accepted exactly one cycle after the last bit of the first word. Streams show 1,1,1 / eight 1s, then 0,0,0 / eight 0s, with no loss or duplication.
- Random toggling of m_ready_x with 100 random words -> the scoreboard reassembles each field LSB first and matches s_data exactly. m_data_x never changes while m_valid_x && !m_ready_x.
- Reset mid-operation: assert aresetn=0 after 2 of 8 stream-2 bits -> m_valid_1, m_valid_2 drop immediately; after release s_ready=1, and the next word serializes correctly from bit 0.
